// File: rtl/mode_select_frontend.sv
// Clocked front end for the mode FSM: button synchronise/debounce, browse/confirm menu,
// 7-segment glyph and valid/ready mode delivery. Define MODE_BLINK_EN to blink the glyph in BROWSE.
module mode_select_frontend #(
  parameter int unsigned DEB_CYCLES     = 2_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_switch_btn,
  input  logic       confirm_btn,
  input  logic       mode_req_ready,
  output logic [1:0] mode_req,
  output logic       mode_req_valid,
  output logic [1:0] active_mode,
  output logic       browsing,
  output logic [6:0] seg_out
);

  localparam int unsigned   DW       = $clog2(DEB_CYCLES + 1);
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BROWSE = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  function automatic logic [6:0] mode_glyph(input logic [1:0] mode);
    logic [6:0] g;
    case (mode)
      2'b00:   g = 7'b0111000;
      2'b01:   g = 7'b0110011;
      2'b10:   g = 7'b0110111;
      2'b11:   g = 7'b0111110;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // Bit 0 = mode switch, bit 1 = confirm.
  logic [1:0]    raw_s;
  logic [1:0]    meta_r, sync_r, deb_r, arm_r, press_r;
  logic [DW-1:0] cnt_r [2];

  assign raw_s = {confirm_btn, mode_switch_btn};

  // Synchronise and debounce both buttons; a press needs a release seen since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r  <= 2'b11;
      sync_r  <= 2'b11;
      deb_r   <= 2'b00;
      arm_r   <= 2'b00;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
      for (int i = 0; i < 2; i++) begin
        press_r[i] <= 1'b0;
        if (sync_r[i] != deb_r[i]) begin
          if (cnt_r[i] == DEB_LAST) begin
            deb_r[i]   <= sync_r[i];
            cnt_r[i]   <= '0;
            press_r[i] <= sync_r[i] & arm_r[i];
          end else begin
            cnt_r[i] <= cnt_r[i] + 1'b1;
          end
        end else begin
          cnt_r[i] <= '0;
          if (sync_r[i] == 1'b0) begin
            arm_r[i] <= 1'b1;
          end else begin
            arm_r[i] <= arm_r[i];
          end
        end
      end
    end
  end

  logic          sw_press_s, cf_press_s;
  state_t        state_r, state_s;
  logic [1:0]    cand_r, cand_s, active_r, active_s, mode_req_r, mode_req_s, disp_s;
  logic          valid_r, valid_s, browsing_r, blank_s;
  logic [TW-1:0] tmo_r, tmo_s;
  logic [6:0]    seg_r;

  assign sw_press_s = press_r[0];
  assign cf_press_s = press_r[1];

  // Menu next-state: confirm beats switch, any press beats the idle timeout.
  always_comb begin
    state_s    = state_r;
    cand_s     = cand_r;
    active_s   = active_r;
    valid_s    = valid_r;
    tmo_s      = tmo_r;
    mode_req_s = mode_req_r;
    case (state_r)
      ST_IDLE: begin
        valid_s = 1'b0;
        tmo_s   = '0;
        if (sw_press_s) begin
          state_s = ST_BROWSE;
          cand_s  = active_r + 2'd1;
        end else begin
          cand_s  = active_r;
        end
      end
      ST_BROWSE: begin
        valid_s = 1'b0;
        if (cf_press_s) begin
          state_s    = ST_COMMIT;
          valid_s    = 1'b1;
          mode_req_s = cand_r;
          tmo_s      = '0;
        end else if (sw_press_s) begin
          cand_s = cand_r + 2'd1;
          tmo_s  = '0;
        end else if (tmo_r == TMO_LAST) begin
          state_s = ST_IDLE;
          cand_s  = active_r;
          tmo_s   = '0;
        end else begin
          tmo_s = tmo_r + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (mode_req_ready) begin
          state_s  = ST_IDLE;
          active_s = cand_r;
          valid_s  = 1'b0;
        end else begin
          valid_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cand_s  = active_r;
        valid_s = 1'b0;
        tmo_s   = '0;
      end
    endcase
  end

  assign disp_s = (state_s == ST_IDLE) ? active_s : cand_s;

`ifdef MODE_BLINK_EN
  localparam int unsigned   BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt_r, blink_cnt_s;
  logic          blink_off_r, blink_off_s;

  // Blink phase restarts on the glyph at BROWSE entry and on every candidate change.
  always_comb begin
    blink_cnt_s = '0;
    blink_off_s = 1'b0;
    if ((state_s != ST_BROWSE) || (state_r != ST_BROWSE) || (cand_s != cand_r)) begin
      blink_cnt_s = '0;
      blink_off_s = 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_s = '0;
      blink_off_s = ~blink_off_r;
    end else begin
      blink_cnt_s = blink_cnt_r + 1'b1;
      blink_off_s = blink_off_r;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_s;
      blink_off_r <= blink_off_s;
    end
  end

  assign blank_s = blink_off_s;
`else
  assign blank_s = 1'b0;
`endif

  // Menu state and output registers; outputs are computed from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cand_r     <= 2'b00;
      active_r   <= 2'b00;
      valid_r    <= 1'b0;
      tmo_r      <= '0;
      mode_req_r <= 2'b00;
      browsing_r <= 1'b0;
      seg_r      <= 7'b0111000;
    end else begin
      state_r    <= state_s;
      cand_r     <= cand_s;
      active_r   <= active_s;
      valid_r    <= valid_s;
      tmo_r      <= tmo_s;
      mode_req_r <= mode_req_s;
      browsing_r <= (state_s == ST_BROWSE);
      seg_r      <= blank_s ? 7'b0000000 : mode_glyph(disp_s);
    end
  end

  assign mode_req       = mode_req_r;
  assign mode_req_valid = valid_r;
  assign active_mode    = active_r;
  assign browsing       = browsing_r;
  assign seg_out        = seg_r;

endmodule

// File: tb/tb_mode_select_frontend.sv
// Self-checking bench for mode_select_frontend: directed scenarios plus randomised button
// operations checked against a press-level menu model.
module tb_mode_select_frontend;

  localparam int DEB = 4;
  localparam int TMO = 50;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_switch_btn = 1'b0;
  logic       confirm_btn = 1'b0;
  logic       mode_req_ready = 1'b0;
  logic [1:0] mode_req, active_mode;
  logic       mode_req_valid, browsing;
  logic [6:0] seg_out;

  mode_select_frontend #(
    .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLK)
  ) dut (
    .clk(clk), .rst(rst), .mode_switch_btn(mode_switch_btn), .confirm_btn(confirm_btn),
    .mode_req_ready(mode_req_ready), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .active_mode(active_mode), .browsing(browsing), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         vcnt = 0;
  logic [1:0] last_req = 2'b00;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mode_req_valid === 1'b1) begin
      vcnt     <= vcnt + 1;
      last_req <= mode_req;
    end
  end

  // Press-level model: 0 IDLE, 1 BROWSE, 2 COMMIT.
  int         m_state, m_evt, m_chg;
  logic [1:0] m_cand, m_active;
  bit         m_xfer;
  logic [6:0] glyph_tab [4] = '{7'b0111000, 7'b0110011, 7'b0110111, 7'b0111110};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cand = 2'b00; m_active = 2'b00; m_evt = 0; m_chg = 0; m_xfer = 1'b0;
  endtask

  task automatic model_advance(input int t);
    if (m_state == 1 && t >= m_evt + TMO) begin
      m_state = 0;
      m_cand  = m_active;
    end
  endtask

  // Press pulses from a clean button change act on the FSM 7 edges after the raw edge.
  task automatic model_press(input bit sw, input bit cf, input int t);
    m_xfer = 1'b0;
    model_advance(t - 1);
    case (m_state)
      0: if (sw) begin m_state = 1; m_cand = m_active + 2'd1; m_evt = t; m_chg = t; end
      1: begin
        if (cf) begin
          if (mode_req_ready) begin m_active = m_cand; m_state = 0; m_xfer = 1'b1; end
          else m_state = 2;
        end else if (sw) begin
          m_cand = m_cand + 2'd1; m_evt = t; m_chg = t;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [6:0] exp_seg();
    if (m_state == 0) return glyph_tab[m_active];
`ifdef MODE_BLINK_EN
    if (m_state == 1 && (((cyc - m_chg) / BLK) % 2) == 1) return 7'b0000000;
`endif
    return glyph_tab[m_cand];
  endfunction

  task automatic check_all(input string tag);
    model_advance(cyc);
    chk({tag, ".browsing"}, {7'b0, browsing}, {7'b0, m_state == 1});
    chk({tag, ".valid"}, {7'b0, mode_req_valid}, {7'b0, m_state == 2});
    chk({tag, ".active"}, {6'b0, active_mode}, {6'b0, m_active});
    chk({tag, ".seg"}, {1'b0, seg_out}, {1'b0, exp_seg()});
    if (m_state == 2) chk({tag, ".mode_req"}, {6'b0, mode_req}, {6'b0, m_cand});
  endtask

  task automatic press(input bit sw, input bit cf);
    int c;
    c = cyc;
    mode_switch_btn = sw;
    confirm_btn     = cf;
    repeat (8) @(negedge clk);
    model_press(sw, cf, c + 7);
    mode_switch_btn = 1'b0;
    confirm_btn     = 1'b0;
    check_all("press_mid");
    repeat (8) @(negedge clk);
    check_all("press_end");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int c, v0, stall;
    model_reset();
    @(negedge clk);
    check_all("reset_state");
    chk("reset_mode_req", {6'b0, mode_req}, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Bouncing input, then a stable press with exact latency.
    for (int i = 0; i < 20; i++) begin
      mode_switch_btn = ((i / 2) % 2 == 0);
      @(negedge clk);
      check_all("bounce");
    end
    c = cyc;
    mode_switch_btn = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 7) begin
        model_press(1'b1, 1'b0, c + 7);
        chk("deb_latency_seg", {1'b0, seg_out}, {1'b0, 7'b0110011});
      end
      check_all("deb_latency");
    end
    mode_switch_btn = 1'b0;
    repeat (10) @(negedge clk);
    check_all("single_press");

    // Wrap through all four modes and commit with ready already high.
    do_reset();
    mode_req_ready = 1'b1;
    repeat (4) press(1'b1, 1'b0);
    v0 = vcnt;
    press(1'b0, 1'b1);
    chk("wrap_valid_width", 8'(vcnt - v0), 8'd1);
    chk("wrap_mode_req", {6'b0, last_req}, 8'h00);

    // Handshake stall with a switch press ignored in COMMIT.
    mode_req_ready = 1'b0;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    c = cyc;
    mode_switch_btn = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 7) model_press(1'b1, 1'b0, c + 7);
      check_all("stall");
    end
    mode_switch_btn = 1'b0;
    mode_req_ready  = 1'b1;
    @(negedge clk);
    m_active = m_cand; m_state = 0;
    mode_req_ready = 1'b0;
    check_all("stall_release");
    chk("stall_active", {6'b0, active_mode}, 8'h02);
    repeat (10) @(negedge clk);

    // Commit FREE, then let a browse time out.
    mode_req_ready = 1'b1;
    repeat (3) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    mode_req_ready = 1'b0;
    press(1'b1, 1'b0);
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      check_all("timeout");
    end
    chk("timeout_browsing", {7'b0, browsing}, 8'h00);
    chk("timeout_glyph", {1'b0, seg_out}, {1'b0, 7'b0110011});

    // Blink pattern (or steady glyph) across a restart.
    press(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check_all("blink");
    end
    press(1'b1, 1'b0);

    // Simultaneous presses, then reset with COMMIT pending.
    press(1'b1, 1'b1);
    chk("simul_mode_req", {6'b0, mode_req}, {6'b0, m_cand});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset_commit");

    // Button held through reset must not press until released.
    mode_switch_btn = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check_all("held_reset");
    end
    mode_switch_btn = 1'b0;
    repeat (12) @(negedge clk);
    press(1'b1, 1'b0);

    // Randomised operations.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: press(1'b1, 1'b0);
        1: begin
          mode_req_ready = 1'b1;
          v0 = vcnt;
          press(1'b0, 1'b1);
          chk("rand_valid_width", 8'(vcnt - v0), m_xfer ? 8'd1 : 8'd0);
          mode_req_ready = 1'b0;
        end
        2: begin
          mode_req_ready = 1'b0;
          press(1'b0, 1'b1);
          stall = $urandom_range(0, 4);
          for (int n = 0; n < stall; n++) begin
            @(negedge clk);
            check_all("rand_stall");
          end
          mode_req_ready = 1'b1;
          @(negedge clk);
          if (m_state == 2) begin m_active = m_cand; m_state = 0; end
          mode_req_ready = 1'b0;
          check_all("rand_handoff");
        end
        default: begin
          repeat ($urandom_range(1, 30)) @(negedge clk);
          check_all("rand_idle");
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
